// File: rtl/upload_frame_decoder.sv
// ============================================================================
// Module  : upload_frame_decoder
// Purpose : Parses AA 44 | src | len_h len_l | payload | checksum upload frames
//           and forwards payload bytes with a status pulse per frame.
//           Optional inter-byte timeout: UPLOAD_DECODER_TIMEOUT_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module upload_frame_decoder #(
    parameter logic [7:0] HEADER_H       = 8'hAA,
    parameter logic [7:0] HEADER_L       = 8'h44,
    parameter int         MAX_LEN        = 256,
    parameter int         TIMEOUT_CYCLES = 60000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic [7:0]  out_source,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_count,
    output logic [15:0] error_count,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_SEEK_H  = 3'd0,
        S_SEEK_L  = 3'd1,
        S_SRC     = 3'd2,
        S_LEN_H   = 3'd3,
        S_LEN_L   = 3'd4,
        S_PAYLOAD = 3'd5,
        S_CHK     = 3'd6
    } state_t;

    // The idle counter is 16 bits wide, so the limit must fit.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_check
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t      state_q, state_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [7:0]  out_source_q, out_source_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        frame_ok_q, frame_ok_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [15:0] error_count_q, error_count_d;
    logic [7:0]  len_h_q, len_h_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] rem_q, rem_d;
    logic        accept;
    logic [15:0] len_w;
    logic [15:0] error_count_inc;
`ifdef UPLOAD_DECODER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] idle_q, idle_d;
`endif

    always_comb begin
        state_d       = state_q;
        out_data_d    = out_data_q;
        out_source_d  = out_source_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        frame_ok_d    = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        frame_count_d = frame_count_q;
        error_count_d = error_count_q;
        len_h_d       = len_h_q;
        csum_d        = csum_q;
        rem_d         = rem_q;

        // Payload is only back-pressured while the output register is occupied.
        in_ready = (state_q == S_PAYLOAD) ? (!out_valid_q || out_ready) : 1'b1;
        accept   = in_valid && in_ready;
        len_w    = {len_h_q, in_data};
        error_count_inc = (error_count_q == 16'hFFFF) ? error_count_q
                                                      : error_count_q + 16'd1;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                S_SEEK_H: begin
                    if (in_data == HEADER_H) state_d = S_SEEK_L;
                end
                S_SEEK_L: begin
                    if (in_data == HEADER_L)      state_d = S_SRC;
                    else if (in_data != HEADER_H) state_d = S_SEEK_H;
                end
                S_SRC: begin
                    out_source_d = in_data;
                    csum_d       = in_data;
                    state_d      = S_LEN_H;
                end
                S_LEN_H: begin
                    len_h_d = in_data;
                    csum_d  = csum_q + in_data;
                    state_d = S_LEN_L;
                end
                S_LEN_L: begin
                    csum_d = csum_q + in_data;
                    rem_d  = len_w;
                    if (len_w > 16'(MAX_LEN)) begin
                        frame_err_d   = 1'b1;
                        err_code_d    = 2'b10;
                        error_count_d = error_count_inc;
                        state_d       = S_SEEK_H;
                    end else if (len_w == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    out_last_d  = (rem_q == 16'd1);
                    csum_d      = csum_q + in_data;
                    rem_d       = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = S_CHK;
                end
                S_CHK: begin
                    if (in_data == csum_q) begin
                        frame_ok_d    = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        frame_err_d   = 1'b1;
                        err_code_d    = 2'b01;
                        error_count_d = error_count_inc;
                    end
                    state_d = S_SEEK_H;
                end
                default: state_d = S_SEEK_H;
            endcase
        end

`ifdef UPLOAD_DECODER_TIMEOUT_EN
        idle_d = 16'd0;
        if (state_q != S_SEEK_H && !accept && !(out_valid_q && !out_ready)) begin
            if (idle_q == TIMEOUT_LAST) begin
                frame_err_d   = 1'b1;
                err_code_d    = 2'b11;
                error_count_d = error_count_inc;
                out_valid_d   = 1'b0;
                state_d       = S_SEEK_H;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_SEEK_H;
            out_data_q    <= 8'd0;
            out_source_q  <= 8'd0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= 2'b00;
            frame_count_q <= 16'd0;
            error_count_q <= 16'd0;
            len_h_q       <= 8'd0;
            csum_q        <= 8'd0;
            rem_q         <= 16'd0;
`ifdef UPLOAD_DECODER_TIMEOUT_EN
            idle_q        <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            out_data_q    <= out_data_d;
            out_source_q  <= out_source_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            frame_ok_q    <= frame_ok_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            frame_count_q <= frame_count_d;
            error_count_q <= error_count_d;
            len_h_q       <= len_h_d;
            csum_q        <= csum_d;
            rem_q         <= rem_d;
`ifdef UPLOAD_DECODER_TIMEOUT_EN
            idle_q        <= idle_d;
`endif
        end
    end

    assign out_data    = out_data_q;
    assign out_source  = out_source_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign frame_ok    = frame_ok_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign frame_count = frame_count_q;
    assign error_count = error_count_q;
    assign busy        = (state_q != S_SEEK_H);

endmodule

`default_nettype wire

// File: tb/tb_upload_frame_decoder.sv
// ============================================================================
// Module  : tb_upload_frame_decoder
// Purpose : Directed and randomized frame stimulus for upload_frame_decoder,
//           checked against a frame-level reference model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_upload_frame_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic [7:0]  out_source;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_count;
    logic [15:0] error_count;
    logic        busy;

    upload_frame_decoder dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_source(out_source), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
        .frame_count(frame_count), .error_count(error_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed traffic: {last, data} per transfer; status 4 = ok, 1..3 = err code.
    logic [8:0] got_q[$];
    int         st_q[$];
    int         st_cyc_q[$];

    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) got_q.push_back({out_last, out_data});
        if (frame_ok && frame_err) begin
            st_q.push_back(99);
            st_cyc_q.push_back(cyc);
        end else if (frame_ok) begin
            st_q.push_back(4);
            st_cyc_q.push_back(cyc);
        end else if (frame_err) begin
            st_q.push_back(int'(err_code));
            st_cyc_q.push_back(cyc);
        end
    end

    // Reference model state
    int         total = 0;
    int         bad = 0;
    bit         bp_en = 1'b0;
    int         last_acc_cyc = 0;
    int         exp_fc = 0;
    int         exp_ec = 0;
    int         exp_code = 0;
    logic [8:0] exp_pay[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the rising edge on which the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 300 && !acc; k++) begin
            #1;
            acc = in_ready;
            if (acc) last_acc_cyc = cyc + 1;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $error("FAIL send_timeout observed=no_accept expected=accept byte=%0h", b);
        end
    endtask

    task automatic finish_frame(input logic [7:0] src, input int exp_st);
        for (int k = 0; k < 300 && out_valid; k++) tick();
        tick();
        tick();
        if (exp_st == 4) exp_fc = (exp_fc + 1) % 65536;
        else begin
            if (exp_ec < 65535) exp_ec++;
            exp_code = exp_st;
        end
        check("payload_count", got_q.size(), exp_pay.size());
        for (int i = 0; i < got_q.size() && i < exp_pay.size(); i++)
            check("payload_byte", {23'd0, got_q[i]}, {23'd0, exp_pay[i]});
        check("status_count", st_q.size(), 1);
        if (st_q.size() > 0) begin
            check("status", st_q[0], exp_st);
            check("status_cycle", st_cyc_q[0], last_acc_cyc);
        end
        check("out_source", {24'd0, out_source}, {24'd0, src});
        check("frame_count", {16'd0, frame_count}, exp_fc);
        check("error_count", {16'd0, error_count}, exp_ec);
        check("err_code", {30'd0, err_code}, exp_code);
        got_q.delete();
        st_q.delete();
        st_cyc_q.delete();
        exp_pay.delete();
    endtask

    // cdelta != 0 corrupts the checksum; fixed payload is 11,22,33,...
    task automatic run_frame(input logic [7:0] src, input logic [15:0] len,
                             input logic [7:0] cdelta, input bit pre_aa,
                             input int gap, input bit rand_pay);
        logic [7:0] sum;
        logic [7:0] b;
        int         st;
        for (int g = 0; g < gap; g++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hAA) b = 8'h55;
            send_byte(b);
        end
        if (pre_aa) send_byte(8'hAA);
        send_byte(8'hAA);
        send_byte(8'h44);
        send_byte(src);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        if (int'(len) > 256) begin
            st = 2;
        end else begin
            sum = src + len[15:8] + len[7:0];
            for (int i = 0; i < int'(len); i++) begin
                b = rand_pay ? 8'($urandom_range(0, 255)) : 8'(8'h11 * (i + 1));
                exp_pay.push_back({(i == int'(len) - 1), b});
                sum = sum + b;
                send_byte(b);
            end
            send_byte(sum + cdelta);
            st = (cdelta == 8'd0) ? 4 : 1;
        end
        finish_frame(src, st);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_outputs", {10'd0, out_data, out_source, out_valid, out_last,
                                frame_ok, frame_err, err_code, busy}, 32'd0);
        check("reset_frame_count", {16'd0, frame_count}, 32'd0);
        check("reset_error_count", {16'd0, error_count}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Basic frame, bad checksum, resync + zero length, length error, good frame
        run_frame(8'h01, 16'd3, 8'h00, 1'b0, 0, 1'b0);
        run_frame(8'h01, 16'd3, 8'hFF, 1'b0, 0, 1'b0);
        run_frame(8'h02, 16'd0, 8'h00, 1'b1, 0, 1'b0);
        run_frame(8'h05, 16'd257, 8'h00, 1'b0, 0, 1'b0);
        run_frame(8'h07, 16'd3, 8'h00, 1'b0, 2, 1'b0);
        run_frame(8'h09, 16'd256, 8'h00, 1'b0, 0, 1'b1);

        // Five-cycle downstream stall while 0x22 is held at the output
        send_byte(8'hAA);
        send_byte(8'h44);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        out_ready = 1'b0;
        in_data   = 8'h33;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h22});
            check("stall_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send_byte(8'h33);
        send_byte(8'h6A);  // 01 + 00 + 03 + 11 + 22 + 33 mod 256
        exp_pay.push_back({1'b0, 8'h11});
        exp_pay.push_back({1'b0, 8'h22});
        exp_pay.push_back({1'b1, 8'h33});
        finish_frame(8'h01, 4);

        // Randomized frames with random downstream back-pressure
        bp_en = 1'b1;
        for (int f = 0; f < 25; f++) begin
            logic [15:0] len;
            logic [7:0]  delta;
            len   = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(257, 2000))
                                                : 16'($urandom_range(0, 6));
            delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            run_frame(8'($urandom_range(0, 255)), len, delta,
                      1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b1);
        end
        bp_en     = 1'b0;
        out_ready = 1'b1;

        // Reset in the middle of a payload
        send_byte(8'hAA);
        send_byte(8'h44);
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h11);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {10'd0, out_data, out_source, out_valid, out_last,
                                 frame_ok, frame_err, err_code, busy}, 32'd0);
        check("midrst_counts", {frame_count, error_count}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        st_q.delete();
        st_cyc_q.delete();
        exp_fc   = 0;
        exp_ec   = 0;
        exp_code = 0;
        @(negedge clk);
        run_frame(8'h3C, 16'd2, 8'h00, 1'b0, 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
